gecko_mem_tracker: RTL and testbench

- Parametrised successor to the fixed-latency memory command stage in the gecko core.
- Holds up to DEPTH in-flight memory commands in order. It pairs each command with its data response from a variable-latency memory and emits the joined {command, data} stream toward writeback.
- Commands that need no response (stores, fences) retire without consuming a response.
- Sits between gecko_execute (command side), the data memory result interface and gecko_writeback.

---
 rtl/gecko_mem_tracker.sv | 161 ++++++++++++++++
 tb/tb_gecko_mem_tracker.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gecko_mem_tracker.sv
// gecko_mem_tracker: in-order tracker that pairs outstanding memory commands
// with their variable-latency data responses and emits the joined
// {command, data} stream toward writeback. Commands that expect no response
// retire without consuming one.
// Optional statistics outputs are enabled with `define GECKO_MEM_TRACKER_STATS_EN.
//
// Handshake rule for all three interfaces: a beat transfers on a rising clk
// edge where valid && ready are both high; valid and payload must be held
// stable until that edge; ready may depend combinationally on valid.
module gecko_mem_tracker #(
   parameter int CMD_WIDTH  = 64,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int OUTPUT_REG = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [CMD_WIDTH-1:0]      cmd_payload,
   input  logic                      cmd_expects_resp,
   input  logic                      resp_valid,
   output logic                      resp_ready,
   input  logic [DATA_WIDTH-1:0]     resp_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CMD_WIDTH-1:0]      out_cmd,
   output logic [DATA_WIDTH-1:0]     out_data,
   output logic [$clog2(DEPTH):0]    inflight,
   output logic                      orphan_flag
`ifdef GECKO_MEM_TRACKER_STATS_EN
   ,
   output logic [31:0]               stat_stall_cycles,
   output logic [$clog2(DEPTH):0]    stat_max_inflight
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   // Entry storage; the pointer MSB separates full from empty.
   logic [CMD_WIDTH-1:0]  r_cmd_mem [DEPTH];
   logic [DEPTH-1:0]      r_exp_mem;
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic                  r_orphan;

   logic [PW-1:0]         w_count;
   logic                  w_head_present;
   logic [CMD_WIDTH-1:0]  w_head_cmd;
   logic                  w_head_exp;
   logic                  w_join_valid;
   logic [DATA_WIDTH-1:0] w_join_data;
   logic                  w_take;
   logic                  w_push;
   logic                  w_pop;

   assign w_count        = r_wr_ptr - r_rd_ptr;
   assign w_head_present = (w_count != '0);
   assign w_head_cmd     = r_cmd_mem[r_rd_ptr[AW-1:0]];
   assign w_head_exp     = r_exp_mem[r_rd_ptr[AW-1:0]];

   // Head is joinable when it needs no response or its response is here now.
   assign w_join_valid = w_head_present && (!w_head_exp || resp_valid);
   assign w_join_data  = w_head_exp ? resp_data : '0;

   assign cmd_ready  = (w_count < PW'(DEPTH));
   assign w_push     = cmd_valid && cmd_ready;
   assign w_pop      = w_join_valid && w_take;
   assign resp_ready = w_take && w_head_present && w_head_exp;

   assign inflight    = w_count;
   assign orphan_flag = r_orphan;

   // Payload storage is written on accept only; no reset needed.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_cmd_mem[r_wr_ptr[AW-1:0]] <= cmd_payload;
         r_exp_mem[r_wr_ptr[AW-1:0]] <= cmd_expects_resp;
      end
   end

   // Pointers advance on push/pop and wrap naturally modulo 2*DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
   end

   // Sticky flag: a response showed up with no head waiting for one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_orphan <= 1'b0;
      end else if (resp_valid && !(w_head_present && w_head_exp)) begin
         r_orphan <= 1'b1;
      end
   end

   generate
      if (OUTPUT_REG != 0) begin : g_out_reg
         logic                  r_out_valid;
         logic [CMD_WIDTH-1:0]  r_out_cmd;
         logic [DATA_WIDTH-1:0] r_out_data;

         // Pipe slice accepts whenever it is empty or being drained this cycle.
         assign w_take = !r_out_valid || out_ready;

         // Output slice: one-deep register, keeps 1 beat/cycle throughput.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_out_valid <= 1'b0;
               r_out_cmd   <= '0;
               r_out_data  <= '0;
            end else if (w_take) begin
               r_out_valid <= w_join_valid;
               if (w_join_valid) begin
                  r_out_cmd  <= w_head_cmd;
                  r_out_data <= w_join_data;
               end
            end
         end

         assign out_valid = r_out_valid;
         assign out_cmd   = r_out_cmd;
         assign out_data  = r_out_data;
      end else begin : g_out_comb
         assign w_take    = out_ready;
         assign out_valid = w_join_valid;
         assign out_cmd   = w_head_cmd;
         assign out_data  = w_join_data;
      end
   endgenerate

`ifdef GECKO_MEM_TRACKER_STATS_EN
   logic [31:0]   r_stall;
   logic [PW-1:0] r_max;
   logic [PW-1:0] w_count_next;

   assign w_count_next      = w_count + PW'(w_push) - PW'(w_pop);
   assign stat_stall_cycles = r_stall;
   assign stat_max_inflight = r_max;

   // Stall counter saturates; peak tracks the occupancy after each edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall <= '0;
         r_max   <= '0;
      end else begin
         if (w_head_present && w_head_exp && !resp_valid && (r_stall != '1)) begin
            r_stall <= r_stall + 32'd1;
         end
         if (w_count_next > r_max) r_max <= w_count_next;
      end
   end
`endif

endmodule

// File: tb/tb_gecko_mem_tracker.sv
// Bench for gecko_mem_tracker: queue-level reference model checked every
// cycle against the combinational-join instance, an in-order scoreboard for
// the randomized traffic, and a directed run of a registered-output instance.
module tb_gecko_mem_tracker;
   localparam int CW    = 64;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int PW    = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst1 = 1'b1;
   always #5 clk = ~clk;

   // instance 0 (OUTPUT_REG=0)
   logic          cmd_valid, cmd_ready, cmd_expects_resp;
   logic [CW-1:0] cmd_payload;
   logic          resp_valid, resp_ready;
   logic [DW-1:0] resp_data;
   logic          out_valid, out_ready;
   logic [CW-1:0] out_cmd;
   logic [DW-1:0] out_data;
   logic [PW-1:0] inflight;
   logic          orphan_flag;

   // instance 1 (OUTPUT_REG=1)
   logic          d1_cmd_valid, d1_cmd_ready, d1_cmd_expects_resp;
   logic [CW-1:0] d1_cmd_payload;
   logic          d1_resp_valid, d1_resp_ready;
   logic [DW-1:0] d1_resp_data;
   logic          d1_out_valid, d1_out_ready;
   logic [CW-1:0] d1_out_cmd;
   logic [DW-1:0] d1_out_data;
   logic [PW-1:0] d1_inflight;
   logic          d1_orphan_flag;

`ifdef GECKO_MEM_TRACKER_STATS_EN
   logic [31:0]   stall0, stall1;
   logic [PW-1:0] max0, max1;
`endif

   gecko_mem_tracker #(.CMD_WIDTH(CW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .OUTPUT_REG(0)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_payload(cmd_payload),
      .cmd_expects_resp(cmd_expects_resp),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd), .out_data(out_data),
      .inflight(inflight), .orphan_flag(orphan_flag)
`ifdef GECKO_MEM_TRACKER_STATS_EN
      , .stat_stall_cycles(stall0), .stat_max_inflight(max0)
`endif
   );

   gecko_mem_tracker #(.CMD_WIDTH(CW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .OUTPUT_REG(1)) dut_reg (
      .clk(clk), .rst(rst1),
      .cmd_valid(d1_cmd_valid), .cmd_ready(d1_cmd_ready), .cmd_payload(d1_cmd_payload),
      .cmd_expects_resp(d1_cmd_expects_resp),
      .resp_valid(d1_resp_valid), .resp_ready(d1_resp_ready), .resp_data(d1_resp_data),
      .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_cmd(d1_out_cmd), .out_data(d1_out_data),
      .inflight(d1_inflight), .orphan_flag(d1_orphan_flag)
`ifdef GECKO_MEM_TRACKER_STATS_EN
      , .stat_stall_cycles(stall1), .stat_max_inflight(max1)
`endif
   );

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model (instance 0) ----------------
   typedef struct packed {
      logic [CW-1:0] cmd;
      logic          exp;
   } ent_t;

   ent_t        mq[$];
   bit          m_orphan = 1'b0;
   logic [31:0] m_stall  = '0;
   int          m_max    = 0;

   // Outputs are checked mid-cycle, then the model takes the coming edge.
   always @(negedge clk) begin : compare
      int   sz;
      logic e_exp;
      logic e_valid;
      ent_t e;
      if (rst) begin
         mq.delete();
         m_orphan = 1'b0;
         m_stall  = '0;
         m_max    = 0;
         check("rst_inflight", 64'(inflight), 64'd0);
         check("rst_out_valid", 64'(out_valid), 64'd0);
         check("rst_resp_ready", 64'(resp_ready), 64'd0);
         check("rst_orphan", 64'(orphan_flag), 64'd0);
      end else begin
         sz      = mq.size();
         e_exp   = (sz > 0) ? mq[0].exp : 1'b0;
         e_valid = (sz > 0) && (!e_exp || resp_valid);
         check("m_cmd_ready", 64'(cmd_ready), 64'(sz < DEPTH));
         check("m_inflight", 64'(inflight), 64'(sz));
         check("m_out_valid", 64'(out_valid), 64'(e_valid));
         check("m_resp_ready", 64'(resp_ready), 64'(out_ready && e_exp));
         check("m_orphan", 64'(orphan_flag), 64'(m_orphan));
         if (e_valid) begin
            check("m_out_cmd", 64'(out_cmd), 64'(mq[0].cmd));
            check("m_out_data", 64'(out_data), 64'(e_exp ? resp_data : 32'h0));
         end
`ifdef GECKO_MEM_TRACKER_STATS_EN
         check("m_stall", 64'(stall0), 64'(m_stall));
         check("m_max", 64'(max0), 64'(m_max));
         if (e_exp && !resp_valid && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`endif
         if (resp_valid && !e_exp) m_orphan = 1'b1;
         if (e_valid && out_ready) void'(mq.pop_front());
         if (cmd_valid && sz < DEPTH) begin
            e.cmd = cmd_payload;
            e.exp = cmd_expects_resp;
            mq.push_back(e);
         end
         if (mq.size() > m_max) m_max = mq.size();
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_cmd(input logic [63:0] p, input logic e);
      cmd_valid        = 1'b1;
      cmd_payload      = p;
      cmd_expects_resp = e;
      tick();
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   // ---------------- scoreboard for randomized traffic ----------------
   logic [CW+DW-1:0] exp_q[$];
   int               rq_due[$];
   logic [DW-1:0]    rq_data[$];

   initial begin
      logic [CW+DW-1:0] t;
      logic [DW-1:0]    rdat;
      int               last_due;
      int               due;
      bit               drained;

      cmd_valid = 0; cmd_payload = '0; cmd_expects_resp = 0;
      resp_valid = 0; resp_data = '0; out_ready = 0;
      d1_cmd_valid = 0; d1_cmd_payload = '0; d1_cmd_expects_resp = 0;
      d1_resp_valid = 0; d1_resp_data = '0; d1_out_ready = 0;

      repeat (2) tick();
      rst = 1'b0;
      tick();
      #3;
      check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_inflight", 64'(inflight), 64'd0);
      check("reset_resp_ready", 64'(resp_ready), 64'd0);
      tick();

      // ---- fill with 4 loads, then 1 response per cycle ----
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) push_cmd(64'hA0 + 64'(i), 1'b1);
      cmd_payload = 64'hA4;
      #3;
      check("full_cmd_ready", 64'(cmd_ready), 64'd0);
      check("full_inflight", 64'(inflight), 64'd4);
      cmd_valid = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         resp_valid = 1'b1;
         resp_data  = 32'h11 * 32'(i + 1);
         #3;
         check("t1_out_valid", 64'(out_valid), 64'd1);
         check("t1_out_cmd", 64'(out_cmd), 64'hA0 + 64'(i));
         check("t1_out_data", 64'(out_data), 64'(32'h11 * 32'(i + 1)));
         check("t1_resp_ready", 64'(resp_ready), 64'd1);
         tick();
      end
      resp_valid = 1'b0;
      #3;
      check("t1_drained", 64'(inflight), 64'd0);
      tick();

      // ---- load A, store B, load C with C's response delayed ----
      push_cmd(64'h0A, 1'b1);
      push_cmd(64'h0B, 1'b0);
      push_cmd(64'h0C, 1'b1);
      cmd_valid = 1'b0;
      resp_valid = 1'b1;
      resp_data  = 32'h11;
      #3;
      check("t2_a_cmd", 64'(out_cmd), 64'h0A);
      check("t2_a_data", 64'(out_data), 64'h11);
      tick();
      resp_valid = 1'b0;
      #3;
      check("t2_b_valid", 64'(out_valid), 64'd1);
      check("t2_b_cmd", 64'(out_cmd), 64'h0B);
      check("t2_b_data", 64'(out_data), 64'h0);
      check("t2_b_resp_ready", 64'(resp_ready), 64'd0);
      tick();
      repeat (3) begin
         #3;
         check("t2_c_wait_valid", 64'(out_valid), 64'd0);
         check("t2_c_wait_resp_ready", 64'(resp_ready), 64'd1);
         tick();
      end
      resp_valid = 1'b1;
      resp_data  = 32'h33;
      #3;
      check("t2_c_cmd", 64'(out_cmd), 64'h0C);
      check("t2_c_data", 64'(out_data), 64'h33);
      tick();
      resp_valid = 1'b0;
      #3;
      check("t2_drained", 64'(inflight), 64'd0);
      tick();

      // ---- downstream backpressure holds the response ----
      out_ready = 1'b0;
      push_cmd(64'h0D, 1'b1);
      cmd_valid  = 1'b0;
      resp_valid = 1'b1;
      resp_data  = 32'h55;
      repeat (2) begin
         #3;
         check("t3_hold_resp_ready", 64'(resp_ready), 64'd0);
         check("t3_hold_valid", 64'(out_valid), 64'd1);
         check("t3_hold_data", 64'(out_data), 64'h55);
         check("t3_hold_inflight", 64'(inflight), 64'd1);
         tick();
      end
      out_ready = 1'b1;
      #3;
      check("t3_release_resp_ready", 64'(resp_ready), 64'd1);
      tick();
      resp_valid = 1'b0;
      #3;
      check("t3_single_transfer", 64'(inflight), 64'd0);
      tick();

      // ---- randomized traffic, response latency 1..5, then drain ----
      last_due = 0;
      drained  = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         drained = (rq_due.size() == 0) && (exp_q.size() == 0) && (inflight == '0);
         if (cyc >= 300 && drained) break;
         cmd_valid        = (cyc < 300) && ($urandom_range(0, 3) != 0);
         cmd_payload      = {$urandom(), $urandom()};
         cmd_expects_resp = ($urandom_range(0, 3) != 0);
         rdat             = $urandom();
         out_ready        = (cyc >= 300) || ($urandom_range(0, 3) != 0);
         if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
            resp_valid = 1'b1;
            resp_data  = rq_data[0];
         end else begin
            resp_valid = 1'b0;
            resp_data  = $urandom();
         end
         #3;
         check("rnd_inflight_bound", 64'(int'(inflight) <= DEPTH), 64'd1);
         if (out_valid && out_ready) begin
            check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               t = exp_q.pop_front();
               check("sb_cmd", 64'(out_cmd), 64'(t[CW+DW-1:DW]));
               check("sb_data", 64'(out_data), 64'(t[DW-1:0]));
            end
         end
         if (resp_valid && resp_ready) begin
            void'(rq_due.pop_front());
            void'(rq_data.pop_front());
         end
         if (cmd_valid && cmd_ready) begin
            if (cmd_expects_resp) begin
               due = cyc + $urandom_range(1, 5);
               if (due < last_due) due = last_due;
               last_due = due;
               rq_due.push_back(due);
               rq_data.push_back(rdat);
               exp_q.push_back({cmd_payload, rdat});
            end else begin
               exp_q.push_back({cmd_payload, 32'h0});
            end
         end
         tick();
      end
      cmd_valid  = 1'b0;
      resp_valid = 1'b0;
      check("rnd_drained", 64'(drained), 64'd1);
      tick();

      // ---- orphan response, then async reset mid-burst ----
      pulse_reset();
      resp_valid = 1'b1;
      resp_data  = 32'h77;
      #3;
      check("orph_resp_ready", 64'(resp_ready), 64'd0);
      check("orph_not_yet", 64'(orphan_flag), 64'd0);
      tick();
      #3;
      check("orph_set", 64'(orphan_flag), 64'd1);
      resp_valid = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) push_cmd(64'hC0 + 64'(i), 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_out_valid", 64'(out_valid), 64'd0);
      check("async_rst_inflight", 64'(inflight), 64'd0);
      check("async_rst_orphan", 64'(orphan_flag), 64'd0);
      cmd_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      resp_valid = 1'b1;
      resp_data  = 32'h99;
      #3;
      check("post_rst_resp_ready", 64'(resp_ready), 64'd0);
      tick();
      #3;
      check("post_rst_orphan", 64'(orphan_flag), 64'd1);
      resp_valid = 1'b0;
      tick();

      // ---- registered output: same fill/drain, one cycle later ----
      rst1 = 1'b0;
      tick();
      d1_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d1_cmd_valid        = 1'b1;
         d1_cmd_payload      = 64'hB0 + 64'(i);
         d1_cmd_expects_resp = 1'b1;
         tick();
      end
      d1_cmd_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         d1_resp_valid = (k < 4);
         d1_resp_data  = 32'h11 * 32'(k + 1);
         #3;
         if (k == 0) begin
            check("reg_first_valid", 64'(d1_out_valid), 64'd0);
            check("reg_full_inflight", 64'(d1_inflight), 64'd4);
         end else begin
            check("reg_out_valid", 64'(d1_out_valid), 64'd1);
            check("reg_out_cmd", 64'(d1_out_cmd), 64'hB0 + 64'(k - 1));
            check("reg_out_data", 64'(d1_out_data), 64'(32'h11 * 32'(k)));
         end
         if (k < 4) check("reg_resp_ready", 64'(d1_resp_ready), 64'd1);
         tick();
      end
      d1_resp_valid = 1'b0;
      #3;
      check("reg_idle_valid", 64'(d1_out_valid), 64'd0);
      check("reg_idle_inflight", 64'(d1_inflight), 64'd0);
`ifdef GECKO_MEM_TRACKER_STATS_EN
      check("reg_stat_stall", 64'(stall1), 64'd3);
      check("reg_stat_max", 64'(max1), 64'd4);
`endif
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
